// File: rtl/renderer_pkg.sv
// Shared definitions for the lane renderer: unit-type encoding, palette and geometry defaults.
package renderer_pkg;

    typedef enum logic [1:0] {
        UT_NONE = 2'b00,
        UT_T1   = 2'b01,
        UT_T2   = 2'b10,
        UT_T3   = 2'b11
    } unit_type_t;

    localparam logic [11:0] COL_T1     = 12'hF00;
    localparam logic [11:0] COL_T2     = 12'h0F0;
    localparam logic [11:0] COL_T3     = 12'h00F;
    localparam logic [11:0] COL_GROUND = 12'h2D2;
    localparam logic [11:0] COL_SKY    = 12'h37B;
    localparam logic [11:0] COL_BLANK  = 12'h000;

    localparam int DEF_UNIT_W      = 10;
    localparam int DEF_LANE_H      = 10;
    localparam int DEF_LANE_X0     = 203;
    localparam int DEF_LANE_Y0     = 386;
    localparam int DEF_LANE_PITCH  = 20;
    localparam int DEF_GROUND_Y    = 396;
    localparam int DEF_COMMIT_LINE = 480;

    function automatic logic [11:0] type_colour(input unit_type_t t);
        logic [11:0] c;
        case (t)
            UT_T1:   c = COL_T1;
            UT_T2:   c = COL_T2;
            UT_T3:   c = COL_T3;
            default: c = COL_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unit_table.sv
// Double-buffered unit table: writes land in the shadow copy, which is published
// to the active copy once per frame at the commit line when a commit is pending.
module unit_table
    import renderer_pkg::*;
#(
    parameter int NUM_UNITS   = 16,
    parameter int NUM_LANES   = 2,
    parameter int LOC_W       = 9,
    parameter int COMMIT_LINE = DEF_COMMIT_LINE,
    localparam int IDX_W      = $clog2(NUM_UNITS),
    localparam int LANE_IW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic [LOC_W-1:0]   upd_loc,
    input  logic [1:0]         upd_type,
    input  logic [LANE_IW-1:0] upd_lane,
    input  logic               frame_commit,
    output logic               commit_done,
    output logic [LOC_W-1:0]   act_loc  [NUM_UNITS],
    output unit_type_t         act_type [NUM_UNITS],
    output logic [LANE_IW-1:0] act_lane [NUM_UNITS]
);

    logic               pending;
    logic               copy_cycle;
    logic [LOC_W-1:0]   sh_loc  [NUM_UNITS];
    unit_type_t         sh_type [NUM_UNITS];
    logic [LANE_IW-1:0] sh_lane [NUM_UNITS];

    assign copy_cycle = pending && (vCount == 10'(COMMIT_LINE)) && (hCount == 10'd0);
    // Writes are held off on the copy edge so a slot is never half-published.
    assign upd_ready  = ~rst && ~copy_cycle;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            commit_done <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                sh_loc[i]   <= '0;
                sh_type[i]  <= UT_NONE;
                sh_lane[i]  <= '0;
                act_loc[i]  <= '0;
                act_type[i] <= UT_NONE;
                act_lane[i] <= '0;
            end
        end else begin
            commit_done <= copy_cycle;
            if (copy_cycle)
                pending <= frame_commit;
            else if (frame_commit)
                pending <= 1'b1;

            if (upd_valid && upd_ready) begin
                sh_loc[upd_idx]  <= upd_loc;
                sh_type[upd_idx] <= unit_type_t'(upd_type);
                sh_lane[upd_idx] <= upd_lane;
            end

            if (copy_cycle) begin
                for (int i = 0; i < NUM_UNITS; i++) begin
                    act_loc[i]  <= sh_loc[i];
                    act_type[i] <= sh_type[i];
                    act_lane[i] <= sh_lane[i];
                end
            end
        end
    end

endmodule

// File: rtl/lane_renderer.sv
// Lane renderer: hit detection over the active unit table and a two-stage pixel pipeline.
// Define UNIT_OUTLINE_EN to draw a black one-pixel outline around each unit.
module lane_renderer
    import renderer_pkg::*;
#(
    parameter int NUM_UNITS   = 16,
    parameter int NUM_LANES   = 2,
    parameter int LOC_W       = 9,
    parameter int UNIT_W      = DEF_UNIT_W,
    parameter int LANE_H      = DEF_LANE_H,
    parameter int LANE_X0     = DEF_LANE_X0,
    parameter int LANE_Y0     = DEF_LANE_Y0,
    parameter int LANE_PITCH  = DEF_LANE_PITCH,
    parameter int GROUND_Y    = DEF_GROUND_Y,
    parameter int COMMIT_LINE = DEF_COMMIT_LINE,
    localparam int IDX_W      = $clog2(NUM_UNITS),
    localparam int LANE_IW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bright,
    input  logic [9:0]         hCount,
    input  logic [9:0]         vCount,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic [LOC_W-1:0]   upd_loc,
    input  logic [1:0]         upd_type,
    input  logic [LANE_IW-1:0] upd_lane,
    input  logic               frame_commit,
    output logic               commit_done,
    output logic [11:0]        rgb
);

    logic [LOC_W-1:0]   act_loc  [NUM_UNITS];
    unit_type_t         act_type [NUM_UNITS];
    logic [LANE_IW-1:0] act_lane [NUM_UNITS];

    unit_table #(
        .NUM_UNITS   (NUM_UNITS),
        .NUM_LANES   (NUM_LANES),
        .LOC_W       (LOC_W),
        .COMMIT_LINE (COMMIT_LINE)
    ) u_table (
        .clk          (clk),
        .rst          (rst),
        .hCount       (hCount),
        .vCount       (vCount),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_idx      (upd_idx),
        .upd_loc      (upd_loc),
        .upd_type     (upd_type),
        .upd_lane     (upd_lane),
        .frame_commit (frame_commit),
        .commit_done  (commit_done),
        .act_loc      (act_loc),
        .act_type     (act_type),
        .act_lane     (act_lane)
    );

    logic [10:0]          h11, v11, y_lo, y_hi, x_lo, x_hi;
    logic [NUM_LANES-1:0] in_band;
    logic                 hit_any;
    logic [IDX_W-1:0]     hit_idx;
`ifdef UNIT_OUTLINE_EN
    logic [NUM_LANES-1:0] band_edge_row;
    logic                 hit_edge;
    logic                 s1_edge;
`endif

    always_comb begin
        h11     = {1'b0, hCount};
        v11     = {1'b0, vCount};
        y_lo    = '0;
        y_hi    = '0;
        in_band = '0;
`ifdef UNIT_OUTLINE_EN
        band_edge_row = '0;
`endif
        for (int l = 0; l < NUM_LANES; l++) begin
            y_lo       = 11'(LANE_Y0 + l * LANE_PITCH);
            y_hi       = y_lo + 11'(LANE_H - 1);
            in_band[l] = (v11 >= y_lo) && (v11 <= y_hi);
`ifdef UNIT_OUTLINE_EN
            band_edge_row[l] = (v11 == y_lo) || (v11 == y_hi);
`endif
        end
    end

    // Scan from the top index down so the lowest-index hit is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        x_lo    = '0;
        x_hi    = '0;
`ifdef UNIT_OUTLINE_EN
        hit_edge = 1'b0;
`endif
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            x_lo = 11'(act_loc[i]) + 11'(LANE_X0);
            x_hi = x_lo + 11'(UNIT_W - 1);
            if ((act_type[i] != UT_NONE) && (int'(act_lane[i]) < NUM_LANES) &&
                in_band[act_lane[i]] && (h11 >= x_lo) && (h11 <= x_hi)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
`ifdef UNIT_OUTLINE_EN
                hit_edge = (h11 == x_lo) || (h11 == x_hi) || band_edge_row[act_lane[i]];
`endif
            end
        end
    end

    logic             s1_bright, s1_hit, s1_band, s1_ground;
    logic [IDX_W-1:0] s1_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_bright <= 1'b0;
            s1_hit    <= 1'b0;
            s1_idx    <= '0;
            s1_band   <= 1'b0;
            s1_ground <= 1'b0;
`ifdef UNIT_OUTLINE_EN
            s1_edge   <= 1'b0;
`endif
        end else begin
            s1_bright <= bright;
            s1_hit    <= hit_any;
            s1_idx    <= hit_idx;
            s1_band   <= |in_band;
            s1_ground <= (vCount >= 10'(GROUND_Y));
`ifdef UNIT_OUTLINE_EN
            s1_edge   <= hit_edge;
`endif
        end
    end

    // The active table only changes on the commit line, outside every lane band,
    // so looking the type up one stage late is safe.
    always_ff @(posedge clk) begin
        if (rst)
            rgb <= COL_BLANK;
        else if (!s1_bright)
            rgb <= COL_BLANK;
        else if (s1_hit && s1_band)
`ifdef UNIT_OUTLINE_EN
            rgb <= s1_edge ? COL_BLANK : type_colour(act_type[s1_idx]);
`else
            rgb <= type_colour(act_type[s1_idx]);
`endif
        else
            rgb <= s1_ground ? COL_GROUND : COL_SKY;
    end

endmodule

// File: tb/tb_lane_renderer.sv
// Self-checking bench for lane_renderer: pixel expectations go through a scoreboard
// queue that a monitor drains two cycles later; control outputs are checked inline.
module tb_lane_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bright = 1'b0;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  upd_idx = '0;
    logic [8:0]  upd_loc = '0;
    logic [1:0]  upd_type = '0;
    logic [0:0]  upd_lane = '0;
    logic        frame_commit = 1'b0;
    logic        commit_done;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        int          due;
        logic [11:0] e;
        logic [10:0] h;
        logic [10:0] v;
    } exp_t;
    exp_t sb[$];

`ifdef UNIT_OUTLINE_EN
    localparam logic [11:0] E_U0_CORNER = 12'h000;
    localparam logic [11:0] E_U3_CORNER = 12'h000;
    localparam logic [11:0] E_U0_LASTCOL = 12'h000;
`else
    localparam logic [11:0] E_U0_CORNER = 12'hF00;
    localparam logic [11:0] E_U3_CORNER = 12'h0F0;
    localparam logic [11:0] E_U0_LASTCOL = 12'hF00;
`endif

    lane_renderer dut (
        .clk          (clk),
        .rst          (rst),
        .bright       (bright),
        .hCount       (hCount),
        .vCount       (vCount),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_idx      (upd_idx),
        .upd_loc      (upd_loc),
        .upd_type     (upd_type),
        .upd_lane     (upd_lane),
        .frame_commit (frame_commit),
        .commit_done  (commit_done),
        .rgb          (rgb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: rgb for the pixel driven at cycle c is valid at the negedge of cycle c+2.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL sb_missed: pixel (%0d,%0d) never sampled", sb[0].h, sb[0].v);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks++;
            if (rgb !== sb[0].e) begin
                errors++;
                $display("FAIL pixel (%0d,%0d): rgb=%03h expected %03h",
                         sb[0].h, sb[0].v, rgb, sb[0].e);
            end
            void'(sb.pop_front());
        end
    end

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pix(input int h, input int v, input bit b, input logic [11:0] e);
        exp_t x;
        @(negedge clk);
        hCount = 10'(h);
        vCount = 10'(v);
        bright = b;
        x.due = cyc + 2;
        x.e   = e;
        x.h   = 11'(h);
        x.v   = 11'(v);
        sb.push_back(x);
    endtask

    task automatic park();
        @(negedge clk);
        hCount = 10'd0;
        vCount = 10'd0;
        bright = 1'b0;
    endtask

    task automatic wr(input int idx, input int loc, input int typ, input int lane);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_idx   = 4'(idx);
        upd_loc   = 9'(loc);
        upd_type  = 2'(typ);
        upd_lane  = 1'(lane);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic commit_req();
        @(negedge clk);
        frame_commit = 1'b1;
        @(negedge clk);
        frame_commit = 1'b0;
    endtask

    // Visit the commit line; exp_copy says whether a publish is expected there.
    task automatic copy_line(input bit exp_copy, input string nm);
        @(negedge clk);
        hCount = 10'd0;
        vCount = 10'd480;
        bright = 1'b0;
        #1 chk({nm, "_ready"}, 12'(upd_ready), exp_copy ? 12'd0 : 12'd1);
        @(negedge clk);
        hCount = 10'd1;
        #1 chk({nm, "_done"}, 12'(commit_done), exp_copy ? 12'd1 : 12'd0);
        @(negedge clk);
        vCount = 10'd0;
        #1 chk({nm, "_done_clr"}, 12'(commit_done), 12'd0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 12'(upd_ready), 12'd0);
        chk("rst_done", 12'(commit_done), 12'd0);
        chk("rst_rgb", rgb, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_rst", 12'(upd_ready), 12'd1);

        pix(203, 386, 1'b1, 12'h37B);
        pix(203, 400, 1'b1, 12'h2D2);

        // Unit 0, lane 0, loc 0: invisible until published
        wr(0, 0, 1, 0);
        pix(205, 388, 1'b1, 12'h37B);
        commit_req();
        copy_line(1'b1, "copy1");
        pix(203, 386, 1'b1, E_U0_CORNER);
        pix(205, 388, 1'b1, 12'hF00);
        pix(212, 390, 1'b1, E_U0_LASTCOL);
        pix(213, 386, 1'b1, 12'h37B);
        pix(202, 386, 1'b1, 12'h37B);
        pix(205, 396, 1'b1, 12'h2D2);
        pix(205, 388, 1'b0, 12'h000);

        // Overlapping units 3 and 5 in lane 1: lower index wins
        wr(5, 50, 3, 1);
        wr(3, 50, 2, 1);
        commit_req();
        copy_line(1'b1, "copy2");
        pix(253, 406, 1'b1, E_U3_CORNER);
        pix(255, 408, 1'b1, 12'h0F0);
        pix(263, 410, 1'b1, 12'h2D2);
        pix(253, 386, 1'b1, 12'h37B);
        pix(205, 388, 1'b1, 12'hF00);

        // Write without commit: nothing changes across the frame boundary
        wr(0, 0, 3, 0);
        pix(205, 388, 1'b1, 12'hF00);
        copy_line(1'b0, "nocommit");
        pix(205, 388, 1'b1, 12'hF00);
        pix(255, 408, 1'b1, 12'h0F0);

        // Commit and write colliding with the copy cycle
        commit_req();
        @(negedge clk);
        hCount       = 10'd0;
        vCount       = 10'd480;
        frame_commit = 1'b1;
        upd_valid    = 1'b1;
        upd_idx      = 4'd7;
        upd_loc      = 9'd100;
        upd_type     = 2'd2;
        upd_lane     = 1'd0;
        #1 chk("collide_ready", 12'(upd_ready), 12'd0);
        @(negedge clk);
        frame_commit = 1'b0;
        upd_valid    = 1'b0;
        hCount       = 10'd1;
        #1 chk("collide_done", 12'(commit_done), 12'd1);
        @(negedge clk);
        vCount = 10'd0;
        #1 chk("collide_done_clr", 12'(commit_done), 12'd0);
        pix(205, 388, 1'b1, 12'h00F);
        // Re-request kept pending alive: the next commit line publishes again
        copy_line(1'b1, "repend");
        pix(305, 388, 1'b1, 12'h37B);
        pix(205, 388, 1'b1, 12'h00F);

        // loc=511 sits past the visible lane span; no wrap into low columns
        wr(0, 511, 1, 0);
        wr(3, 0, 0, 0);
        wr(5, 0, 0, 0);
        commit_req();
        copy_line(1'b1, "copy511");
        for (int h = 0; h < 640; h++) pix(h, 386, 1'b1, 12'h37B);
        for (int h = 200; h < 280; h++) pix(h, 408, 1'b1, 12'h2D2);
        pix(714, 386, 1'b0, 12'h000);

        // Reset with a commit pending discards it
        wr(2, 0, 1, 0);
        commit_req();
        park();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("rst2_rgb", rgb, 12'h000);
        rst = 1'b0;
        copy_line(1'b0, "post_rst");
        pix(205, 388, 1'b1, 12'h37B);
        pix(255, 408, 1'b1, 12'h2D2);

        park();
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: %0d entries remain, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_renderer.md
LANE_RENDERER -- requirements
Module: lane_renderer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 16: number of unit slots.
REQ-002 SHALL have parameter NUM_LANES, default 2: number of horizontal lanes.
REQ-003 SHALL have parameter LOC_W, default 9: unit location width.
REQ-004 SHALL have parameters UNIT_W=10, LANE_H=10, LANE_X0=203, LANE_Y0=386, LANE_PITCH=20, GROUND_Y=396, COMMIT_LINE=480: geometry in pixels/lines.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports bright (input, 1), hCount (input, 10) and vCount (input, 10): display-timing inputs.
REQ-008 SHALL have port upd_valid, input, 1: a unit write is offered.
REQ-009 SHALL have port upd_ready, output, 1: a unit write can be accepted.
REQ-010 SHALL have ports upd_idx (input, clog2(NUM_UNITS)), upd_loc (input, LOC_W), upd_type (input, 2) and upd_lane (input, max(1,clog2(NUM_LANES))): unit write data.
REQ-011 SHALL have port frame_commit, input, 1: request to publish the shadow table.
REQ-012 SHALL have port commit_done, output, 1: one-cycle pulse after publish.
REQ-013 SHALL have port rgb, output, 12: pixel colour.

Function
REQ-014 SHALL accept a write on every clk edge with upd_valid && upd_ready, storing loc/type/lane into shadow slot upd_idx; a write to the same slot in a later cycle overwrites it.
REQ-015 SHALL drive upd_ready = ~rst && ~copy_cycle.
REQ-016 SHALL set pending on frame_commit; repeated requests before the copy merge into one.
REQ-017 SHALL define copy_cycle = pending && vCount==COMMIT_LINE && hCount==0; on that edge SHALL copy all shadow slots to the active table and clear pending.
REQ-018 SHALL treat frame_commit asserted on copy_cycle as a new request, leaving pending=1 afterwards.
REQ-019 SHALL pulse commit_done for exactly the cycle after copy_cycle.
REQ-020 SHALL render from the active table only, so shadow writes never appear mid-frame.
REQ-021 SHALL define lane L's band as vCount in [LANE_Y0+L*LANE_PITCH, LANE_Y0+L*LANE_PITCH+LANE_H-1].
REQ-022 SHALL define a hit on unit i as type!=0, lane==L for the band containing vCount, and hCount in [loc+LANE_X0, loc+LANE_X0+UNIT_W-1].
REQ-023 SHALL compute the hit-window bounds at 11 bits, so they never wrap.
REQ-024 SHALL resolve overlapping hits by lowest index.
REQ-025 SHALL select colour as follows: type 01→12'hF00, 10→12'h0F0, 11→12'h00F.
REQ-026 SHALL output background when there is no hit: 12'h2D2 if vCount>=GROUND_Y, else 12'h37B.
REQ-027 SHALL output 12'h000 whenever bright=0, regardless of hits.
REQ-028 SHALL pipeline rendering in two stages: stage 1 registers the hit index/valid, lane-band flags, bright and the background select; stage 2 registers rgb.
REQ-029 SHALL give rgb a fixed latency of 2 clk cycles from hCount/vCount/bright.

Reset
REQ-030 SHALL, on rst, clear both tables (type=0, loc=0, lane=0), pending=0, commit_done=0, pipeline registers to not-bright, and rgb=12'h000.
REQ-031 SHALL, on rst mid-frame or with a commit pending, discard the pending commit; the first post-reset frame renders background only.

Configuration
REQ-032 SHALL, with UNIT_OUTLINE_EN defined, draw a hit pixel as 12'h000 if it lies on the first/last unit column or the first/last band row.
REQ-033 SHALL, without UNIT_OUTLINE_EN, draw units solid, with no outline logic synthesised.

Structure
REQ-034 SHALL place the colour constants, the unit-type encoding (NONE/T1/T2/T3) and the geometry defaults in package renderer_pkg.
REQ-035 SHALL implement the shadow/active storage and commit logic in sub-module unit_table; lane_renderer holds hit detection and the pipeline.

Verification
REQ-036 SHALL cover: reset, then unit 0 written loc=0, type=01, lane=0, then commit → after the copy line, pixel (203,386) is F00 two cycles later and pixel (213,386) is 37B.
REQ-037 SHALL cover: units 3 (type 10) and 5 (type 11), both loc=50, lane=1 → pixel (253,406) is 0F0.
REQ-038 SHALL cover: a write without a commit → no change across a full frame and commit_done stays 0.
REQ-039 SHALL cover: frame_commit and upd_valid together on the copy cycle → upd_ready=0 so the write is not accepted; pending=1 afterwards; commit_done=1 next cycle.
REQ-040 SHALL cover: loc=511 with LANE_X0=203 → no hit anywhere, since the 11-bit bounds do not wrap; bright=0 → rgb=000.
REQ-041 SHALL cover: with UNIT_OUTLINE_EN, unit at loc=0, lane 0 → (203,386)=000, (205,388)=F00.
